ltc2308_responder: RTL and testbench
====================================

# ltc2308_responder

Synthesizable responder for the LTC2308 4-wire SPI link: it behaves like the ADC at the far end of the ADC controller's CONVST/SCK/SDI/SDO pins. It returns per-channel 12-bit values supplied on a parallel input. It is used on the DE1-SoC for loopback self-test of the ADC controller and its Avalon software path, with no physical ADC. The block follows the LTC2308 pipelined behaviour: the config word shifted in during frame N selects the channel for frame N+1.

## Interface
- CONV_CYCLES, 80, clk cycles of emulated conversion time (1.6 us at 50 MHz); legal range 4..1023
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- convst  in  1  from controller; asynchronous to clk, synchronized internally
- sck  in  1  from controller; asynchronous, synchronized internally; frequency ≤ clk/8
- sdi  in  1  config bits from controller, MSB first
- sdo  out  1  result bits to controller, MSB first
- chan_data  in  96  channel values; CHk = chan_data[12k+11:12k], unsigned
- busy  out  1  high while in CONV
- cfg_active  out  6  config used by the current/last conversion {S/D,O/S,S1,S0,UNI,SLP}
- frame_err  out  1  sticky protocol-error flag

## Operation
- Input conditioning:
  - convst and sck each pass through a 2-FF synchronizer, then an edge-detect register.
  - sdi is sampled from its own 2-FF synchronizer at the detected sck rise.
- FSM states: IDLE, CONV, SHIFT.
- IDLE: sdo=0. A convst rise goes to CONV, loads cfg_active ← cfg_next, clears the counter.
- CONV:
  - busy=1, sdo=0; counts CONV_CYCLES clk cycles.
  - On the terminal count it captures the result into a 12-bit shift register, then:
    - sets bit counter rx=0 and tx=0;
    - drives sdo=result[11];
    - goes to SHIFT.
- Channel decode: ch = {S1,S0,O/S} (000→CH0, 100→CH1? no: index = S1·4+S0·2+O/S; 001→CH1... ), i.e. ch index = {S1,S0,O/S} read as a 3-bit binary number, applied identically for S/D=0 and S/D=1. S/D is carried only in cfg_active.
- Result arithmetic:
  - UNI=1: result = CHch.
  - UNI=0: result = CHch ^ 12'h800 (offset binary → two's complement).
- SHIFT:
  - sck rise with rx<6: shift sdi into cfg_shift, rx++.
  - sck fall with tx<12: tx++; shift result left; sdo = next bit.
  - After the 12th fall, sdo=0.
  - Further sck edges are ignored.
- Frame end: a convst rise in SHIFT ends the frame, then:
  - cfg_next ← cfg_shift if rx==6; otherwise cfg_next is unchanged and frame_err=1;
  - a new conversion starts (same as the IDLE convst rise, using the updated cfg_next).
- Error cases (frame_err=1, sticky until reset):
  - any sck edge during CONV; the edge is otherwise ignored;
  - convst rise during CONV; it does not restart the conversion;
  - convst rise in SHIFT with rx<6.
- SLP is stored but has no effect.
- Reset mid-frame:
  - returns to IDLE next cycle;
  - sdo=0, busy=0, frame_err=0;
  - cfg_next=cfg_active=6'b100010 (single-ended CH0, unipolar);
  - synchronizer and edge registers clear to 0.

## Timing
- Pin edge to internal event: 3 clk cycles (2 sync + 1 edge register).
- convst rise at pin → busy=1 at cycle 3; busy falls CONV_CYCLES cycles later.
- First sdo bit valid in the same cycle busy falls.
- sck fall at pin → next sdo bit is driven at cycle 3. The controller samples sdo on the following sck rise, so sck high/low phases must each be ≥4 clk.
- chan_data is sampled once, in the cycle CONV terminates; later changes do not affect the frame in flight.
- Simultaneous sck and convst events in one cycle: convst takes priority; the sck edge is dropped.
- All outputs are registered.

## Test plan
- Reset with chan_data CH0=12'hABC → busy=0, sdo=0, frame_err=0, cfg_active=6'b100010.
  - Then a convst pulse and 12 sck cycles with sdi=0 → sdo bits 1010_1011_1100, busy high exactly 80 cycles.
- Frame 1: sdi=6'b110110, CH3=12'h123 → frame 1 still returns CH0.
  - Frame 2 returns CH3 bits 0001_0010_0011.
  - cfg_active=6'b110110 during frame 2.
- Config UNI=0, CH0=12'h000 → next frame returns 12'h800; CH0=12'hFFF → 12'h7FF.
- Toggle sck during CONV → frame_err=1 and stays 1. The result still shifts correctly after CONV.
- Start a new frame after only 3 sck cycles → frame_err=1; cfg_next is unchanged, so the next frame reads the same channel as before.
- Assert reset mid-SHIFT (after 5 bits) → next cycle state is IDLE, sdo=0, cfg_active=6'b100010.
  - A subsequent full frame returns CH0.

Source files
------------

// File: rtl/ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : ltc2308_responder
// Brief    : Emulates the far end of an LTC2308 SPI link, returning per-channel
//            12-bit values with the part's pipelined channel selection.
// Revision : 1.0
// ============================================================================
module ltc2308_responder #(
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        convst,
    input  logic        sck,
    input  logic        sdi,
    output logic        sdo,
    input  logic [95:0] chan_data,
    output logic        busy,
    output logic [5:0]  cfg_active,
    output logic        frame_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_conv  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [5:0] c_cfg_rst  = 6'b100010;
    localparam logic [9:0] c_cnt_last = 10'(CONV_CYCLES - 1);

    logic [1:0]  r_state;
    logic        r_convst_s1, r_convst_s2, r_convst_d;
    logic        r_sck_s1, r_sck_s2, r_sck_d;
    logic        r_sdi_s1, r_sdi_s2;
    logic [9:0]  r_cnt;
    logic [2:0]  r_rx;
    logic [3:0]  r_tx;
    logic [11:0] r_shift;
    logic [5:0]  r_cfg_shift;
    logic [5:0]  r_cfg_next;

    logic        w_convst_rise, w_sck_rise, w_sck_fall;
    logic [2:0]  w_ch;
    logic [11:0] w_raw, w_result;
    logic [5:0]  w_cfg_upd;

    assign w_convst_rise = r_convst_s2 & ~r_convst_d;
    assign w_sck_rise    = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall    = ~r_sck_s2 & r_sck_d;

    // Channel index is {S1,S0,O/S}; S/D does not alter the mapping.
    assign w_ch = {cfg_active[3], cfg_active[2], cfg_active[4]};

    always_comb begin
        w_raw = 12'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_ch == 3'(k)) w_raw = chan_data[12*k +: 12];
        end
    end

    assign w_result  = w_raw ^ {~cfg_active[1], 11'd0};
    assign w_cfg_upd = (r_rx == 3'd6) ? r_cfg_shift : r_cfg_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_convst_s1 <= 1'b0;
            r_convst_s2 <= 1'b0;
            r_convst_d  <= 1'b0;
            r_sck_s1    <= 1'b0;
            r_sck_s2    <= 1'b0;
            r_sck_d     <= 1'b0;
            r_sdi_s1    <= 1'b0;
            r_sdi_s2    <= 1'b0;
            r_cnt       <= 10'd0;
            r_rx        <= 3'd0;
            r_tx        <= 4'd0;
            r_shift     <= 12'd0;
            r_cfg_shift <= 6'd0;
            r_cfg_next  <= c_cfg_rst;
            cfg_active  <= c_cfg_rst;
            sdo         <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_convst_s1 <= convst;
            r_convst_s2 <= r_convst_s1;
            r_convst_d  <= r_convst_s2;
            r_sck_s1    <= sck;
            r_sck_s2    <= r_sck_s1;
            r_sck_d     <= r_sck_s2;
            r_sdi_s1    <= sdi;
            r_sdi_s2    <= r_sdi_s1;

            case (r_state)
                c_st_idle: begin
                    sdo  <= 1'b0;
                    busy <= 1'b0;
                    if (w_convst_rise) begin
                        r_state    <= c_st_conv;
                        cfg_active <= r_cfg_next;
                        r_cnt      <= 10'd0;
                        busy       <= 1'b1;
                    end
                end
                c_st_conv: begin
                    sdo <= 1'b0;
                    if (w_convst_rise || w_sck_rise || w_sck_fall) frame_err <= 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_shift <= w_result;
                        sdo     <= w_result[11];
                        r_rx    <= 3'd0;
                        r_tx    <= 4'd0;
                        busy    <= 1'b0;
                        r_state <= c_st_shift;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                c_st_shift: begin
                    // A frame-ending convst wins over any sck edge in the same cycle.
                    if (w_convst_rise) begin
                        if (r_rx != 3'd6) frame_err <= 1'b1;
                        r_cfg_next <= w_cfg_upd;
                        cfg_active <= w_cfg_upd;
                        r_cnt      <= 10'd0;
                        busy       <= 1'b1;
                        sdo        <= 1'b0;
                        r_state    <= c_st_conv;
                    end else begin
                        if (w_sck_rise && r_rx < 3'd6) begin
                            r_cfg_shift <= {r_cfg_shift[4:0], r_sdi_s2};
                            r_rx        <= r_rx + 3'd1;
                        end
                        if (w_sck_fall && r_tx < 4'd12) begin
                            r_tx    <= r_tx + 4'd1;
                            r_shift <= {r_shift[10:0], 1'b0};
                            sdo     <= r_shift[10];
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    sdo     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ltc2308_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc2308_responder
// Brief    : Self-checking bench for ltc2308_responder against a frame-level
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_ltc2308_responder;

    localparam int CONV = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        convst = 1'b0;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic [95:0] chan_data = 96'd0;
    logic        sdo;
    logic        busy;
    logic [5:0]  cfg_active;
    logic        frame_err;

    ltc2308_responder #(.CONV_CYCLES(CONV)) dut (
        .clk        (clk),
        .reset      (reset),
        .convst     (convst),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .chan_data  (chan_data),
        .busy       (busy),
        .cfg_active (cfg_active),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model state
    logic [5:0]  m_cfg_next, m_cfg_active, m_sent;
    bit          m_err, m_in_frame;
    int          m_rises;
    logic [11:0] m_expect;
    logic [11:0] got;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] model_result(input logic [5:0] cfg, input logic [95:0] cd);
        int ch;
        int v;
        ch = int'(cfg[3]) * 4 + int'(cfg[2]) * 2 + int'(cfg[4]);
        v  = int'(cd[ch*12 +: 12]);
        if (cfg[1] == 1'b0) v = (v + 2048) % 4096;
        return v[11:0];
    endfunction

    task automatic model_reset;
        m_cfg_next   = 6'b100010;
        m_cfg_active = 6'b100010;
        m_err        = 1'b0;
        m_in_frame   = 1'b0;
        m_rises      = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        convst = 1'b0;
        sck = 1'b0;
        sdi = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        model_reset();
        tick;
    endtask

    task automatic start_frame(input bit glitch);
        int lat;
        int width;
        if (m_in_frame) begin
            if (m_rises >= 6) m_cfg_next = m_sent;
            else m_err = 1'b1;
        end
        m_cfg_active = m_cfg_next;
        m_in_frame   = 1'b1;
        m_rises      = 0;
        m_expect     = model_result(m_cfg_active, chan_data);
        if (glitch) m_err = 1'b1;

        convst = 1'b1;
        lat = 0;
        while (!busy && lat < 10) begin
            tick;
            lat++;
        end
        check("busy_latency", lat, 3);
        check("cfg_active", 32'(cfg_active), 32'(m_cfg_active));
        width = 0;
        while (busy && width < 2000) begin
            tick;
            width++;
            if (width == 3) convst = 1'b0;
            if (glitch && width == 10) sck = 1'b1;
            if (glitch && width == 20) sck = 1'b0;
        end
        convst = 1'b0;
        sck = 1'b0;
        check("busy_width", width, CONV);
    endtask

    task automatic shift_frame(input int n, input logic [5:0] cfg, output logic [11:0] data);
        m_sent  = cfg;
        m_rises = n;
        data    = 12'd0;
        for (int i = 0; i < n; i++) begin
            sdi = (i < 6) ? cfg[5-i] : 1'b0;
            tick;
            sck = 1'b1;
            data = {data[10:0], sdo};
            repeat (6) tick;
            sck = 1'b0;
            repeat (6) tick;
        end
        sdi = 1'b0;
    endtask

    task automatic full_frame(input logic [5:0] cfg, input bit glitch, input string tag);
        start_frame(glitch);
        shift_frame(12, cfg, got);
        check(tag, 32'(got), 32'(m_expect));
        check("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    initial begin
        chan_data = {$urandom, $urandom, $urandom};
        chan_data[11:0]  = 12'hABC;
        chan_data[47:36] = 12'h123;
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_sdo", 32'(sdo), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_cfg", 32'(cfg_active), 32'b100010);

        full_frame(6'b000000, 1'b0, "ch0_uni");
        full_frame(6'b110110, 1'b0, "ch0_bipolar");
        full_frame(6'b000000, 1'b0, "ch3_uni");
        chan_data[11:0] = 12'h000;
        full_frame(6'b000000, 1'b0, "bip_zero");
        chan_data[11:0] = 12'hFFF;
        full_frame(6'b000000, 1'b0, "bip_full");

        full_frame(6'b000000, 1'b1, "sck_in_conv");
        full_frame(6'b000000, 1'b0, "err_sticky");

        // Short frame leaves the pipelined config untouched
        do_reset();
        full_frame(6'b110110, 1'b0, "pre_short");
        start_frame(1'b0);
        shift_frame(3, 6'b000000, got);
        full_frame(6'b000000, 1'b0, "after_short");

        // Reset in the middle of a frame
        do_reset();
        full_frame(6'b011110, 1'b0, "pre_midrst");
        start_frame(1'b0);
        shift_frame(5, 6'b000000, got);
        reset = 1'b1;
        tick;
        check("midrst_sdo", 32'(sdo), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(frame_err), 0);
        check("midrst_cfg", 32'(cfg_active), 32'b100010);
        reset = 1'b0;
        model_reset();
        tick;
        full_frame(6'b000000, 1'b0, "post_midrst");

        // Randomized frames; data changed mid-frame must not disturb the result
        for (int f = 0; f < 24; f++) begin
            logic [5:0] cfg;
            int n;
            cfg = 6'($urandom);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 5) : 12;
            chan_data = {$urandom, $urandom, $urandom};
            start_frame(1'b0);
            chan_data = {$urandom, $urandom, $urandom};
            shift_frame(n, cfg, got);
            if (n == 12) check("rand_data", 32'(got), 32'(m_expect));
            check("rand_err", 32'(frame_err), 32'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
